// File: rtl/lstm_pkg.sv
// ----------------------------------------------------------------------------
// lstm_pkg
// Shared definitions for the LSTM training sequencers (fsm_bp and the address
// generators). Holds the default layer sizing, the weight-update state
// encoding and a helper that sizes loop counters.
// ----------------------------------------------------------------------------
package lstm_pkg;

    // Default layer sizing shared by the sequencers
    localparam int ADDR_WIDTH_DEF = 12;
    localparam int TIMESTEP_DEF   = 7;
    localparam int NUM_CELL_DEF   = 8;
    localparam int NUM_INPUT_DEF  = 53;
    localparam int UPD_DELAY_DEF  = 2;

    // Weight-update sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_WAIT = 2'd2,
        ST_WR   = 2'd3
    } upd_state_e;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/addr_gen_upd_w_cnt_wrap.sv
// ----------------------------------------------------------------------------
// cnt_wrap
// Loop counter running 0..MAX_VAL and wrapping back to 0.
//
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (count -> 0)
//   en_i    : advance the count by one (wraps after MAX_VAL)
//   clr_i   : synchronous clear (count -> 0), takes priority over en_i
//   cnt_o   : current count
//   wrap_o  : count is at MAX_VAL, so the next enabled step wraps to 0
// ----------------------------------------------------------------------------
module cnt_wrap #(
    parameter int MAX_VAL = 1,
    parameter int WIDTH   = lstm_pkg::cnt_width(MAX_VAL)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign wrap_o = (cnt_q == MAX_C);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/addr_gen_upd_w.sv
// ----------------------------------------------------------------------------
// addr_gen_upd_w
// Address generator / sequencer for the LSTM weight-gradient update pass.
// For every weight element W[j][i] it streams TIMESTEP accumulate cycles
// (dgate[t][j] * x[t][i]), waits DELAY cycles for the MAC/update latency,
// then issues one write of the updated element. Element order is i inner,
// j outer. Addresses are built with stride adders only.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, aborts a pass immediately
//   start    : one-cycle request for a full pass (ignored while busy)
//   o_addr_d : delta-gate read address  t*NUM_CELL  + j
//   o_addr_x : input/hidden read address t*NUM_INPUT + i
//   o_addr_w : weight address j*NUM_INPUT + i (old-weight read and write)
//   acc      : MAC accumulate enable
//   rst_acc  : MAC accumulator clear
//   wr_w     : weight write strobe
//   busy     : pass in progress
//   done     : one-cycle pulse after the final write
// All outputs are registered.
// ----------------------------------------------------------------------------
module addr_gen_upd_w
    import lstm_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int TIMESTEP   = TIMESTEP_DEF,
    parameter int NUM_CELL   = NUM_CELL_DEF,
    parameter int NUM_INPUT  = NUM_INPUT_DEF,
    parameter int DELAY      = UPD_DELAY_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] o_addr_d,
    output logic [ADDR_WIDTH-1:0] o_addr_x,
    output logic [ADDR_WIDTH-1:0] o_addr_w,
    output logic                  acc,
    output logic                  rst_acc,
    output logic                  wr_w,
    output logic                  busy,
    output logic                  done
);

    localparam int TW = cnt_width(TIMESTEP - 1);
    localparam int IW = cnt_width(NUM_INPUT - 1);
    localparam int JW = cnt_width(NUM_CELL - 1);
    // With DELAY=0 the WAIT state is never entered; the counter is kept at a
    // legal size so the structure is identical for every parameter set.
    localparam int DMAX = (DELAY > 0) ? DELAY - 1 : 0;
    localparam int DW   = cnt_width(DMAX);

    localparam logic [ADDR_WIDTH-1:0] STRIDE_D = ADDR_WIDTH'(NUM_CELL);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_X = ADDR_WIDTH'(NUM_INPUT);

    upd_state_e state_q;

    logic [TW-1:0] t_cnt;
    logic [IW-1:0] i_cnt;
    logic [JW-1:0] j_cnt;
    logic [DW-1:0] d_cnt;
    logic          t_wrap, i_wrap, j_wrap, d_wrap;
    logic          t_en, i_en, j_en, d_en, cnt_clr;

    // Row base j*NUM_INPUT of the current element
    logic [ADDR_WIDTH-1:0] w_row_q;

    // Starting (t=0) addresses of the element after the current one
    logic [ADDR_WIDTH-1:0] x_first;
    logic [ADDR_WIDTH-1:0] d_first;
    logic                  last_elem;

    // Only the wrap flags of t and d drive the sequencing
    logic unused_cnt;
    assign unused_cnt = ^{t_cnt, d_cnt};

    assign t_en    = (state_q == ST_ACC);
    assign d_en    = (state_q == ST_WAIT);
    assign i_en    = (state_q == ST_WR);
    assign j_en    = i_en & i_wrap;
    assign cnt_clr = (state_q == ST_IDLE);

    cnt_wrap #(.MAX_VAL(TIMESTEP - 1), .WIDTH(TW)) u_cnt_t (
        .clk_i (clk), .rst_i (rst), .en_i (t_en), .clr_i (cnt_clr),
        .cnt_o (t_cnt), .wrap_o (t_wrap)
    );

    cnt_wrap #(.MAX_VAL(NUM_INPUT - 1), .WIDTH(IW)) u_cnt_i (
        .clk_i (clk), .rst_i (rst), .en_i (i_en), .clr_i (cnt_clr),
        .cnt_o (i_cnt), .wrap_o (i_wrap)
    );

    cnt_wrap #(.MAX_VAL(NUM_CELL - 1), .WIDTH(JW)) u_cnt_j (
        .clk_i (clk), .rst_i (rst), .en_i (j_en), .clr_i (cnt_clr),
        .cnt_o (j_cnt), .wrap_o (j_wrap)
    );

    cnt_wrap #(.MAX_VAL(DMAX), .WIDTH(DW)) u_cnt_d (
        .clk_i (clk), .rst_i (rst), .en_i (d_en), .clr_i (cnt_clr),
        .cnt_o (d_cnt), .wrap_o (d_wrap)
    );

    assign last_elem = i_wrap & j_wrap;

    // At t=0 the x address is just i and the delta address is just j;
    // stepping i either adds one or wraps to 0 and moves j on by one.
    always_comb begin
        x_first = i_wrap ? '0 : ADDR_WIDTH'(i_cnt) + 1'b1;
        d_first = ADDR_WIDTH'(j_cnt);
        if (i_wrap) begin
            d_first = j_wrap ? '0 : ADDR_WIDTH'(j_cnt) + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            o_addr_d <= '0;
            o_addr_x <= '0;
            o_addr_w <= '0;
            w_row_q  <= '0;
            acc      <= 1'b0;
            rst_acc  <= 1'b1;
            wr_w     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_ACC;
                        o_addr_d <= '0;
                        o_addr_x <= '0;
                        o_addr_w <= '0;
                        w_row_q  <= '0;
                        acc      <= 1'b1;
                        rst_acc  <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                ST_ACC: begin
                    if (t_wrap) begin
                        // Last timestep: addresses hold until the write
                        acc <= 1'b0;
                        if (DELAY == 0) begin
                            state_q <= ST_WR;
                            wr_w    <= 1'b1;
                            rst_acc <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end else begin
                        o_addr_d <= o_addr_d + STRIDE_D;
                        o_addr_x <= o_addr_x + STRIDE_X;
                    end
                end

                ST_WAIT: begin
                    if (d_wrap) begin
                        state_q <= ST_WR;
                        wr_w    <= 1'b1;
                        rst_acc <= 1'b1;
                    end
                end

                ST_WR: begin
                    wr_w <= 1'b0;
                    if (last_elem) begin
                        state_q  <= ST_IDLE;
                        o_addr_d <= '0;
                        o_addr_x <= '0;
                        o_addr_w <= '0;
                        w_row_q  <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        state_q  <= ST_ACC;
                        acc      <= 1'b1;
                        rst_acc  <= 1'b0;
                        o_addr_d <= d_first;
                        o_addr_x <= x_first;
                        // i wrapping moves the weight address to the next row
                        if (i_wrap) begin
                            w_row_q  <= w_row_q + STRIDE_X;
                            o_addr_w <= w_row_q + STRIDE_X;
                        end else begin
                            o_addr_w <= o_addr_w + 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr_gen_upd_w.sv
// ----------------------------------------------------------------------------
// tb_addr_gen_upd_w
// Scoreboard bench: the driver pushes expected output events (accumulate
// cycles, writes, done) with their expected cycle numbers when it issues a
// start; per-DUT monitors pop and compare whenever the DUT shows an event.
// dut  : TIMESTEP=3, NUM_CELL=2, NUM_INPUT=3, DELAY=1
// dut0 : TIMESTEP=1, NUM_CELL=2, NUM_INPUT=3, DELAY=0
// ----------------------------------------------------------------------------
module tb_addr_gen_upd_w;

    typedef struct {
        int kind;   // 0 = acc cycle, 1 = write, 2 = done
        int a;      // acc: o_addr_d, write: o_addr_w, done: 0
        int b;      // acc: o_addr_x, otherwise 0
        int c;      // 2*busy + rst_acc
        int cyc;    // absolute cycle number of the event
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic [11:0] d_a, x_a, w_a, d_b, x_b, w_b;
    logic acc_a, racc_a, wr_a, busy_a, done_a;
    logic acc_b, racc_b, wr_b, busy_b, done_b;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    ev_t qa[$];
    ev_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addr_gen_upd_w #(
        .ADDR_WIDTH(12), .TIMESTEP(3), .NUM_CELL(2), .NUM_INPUT(3), .DELAY(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start_a),
        .o_addr_d(d_a), .o_addr_x(x_a), .o_addr_w(w_a),
        .acc(acc_a), .rst_acc(racc_a), .wr_w(wr_a), .busy(busy_a), .done(done_a)
    );

    addr_gen_upd_w #(
        .ADDR_WIDTH(12), .TIMESTEP(1), .NUM_CELL(2), .NUM_INPUT(3), .DELAY(0)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start_b),
        .o_addr_d(d_b), .o_addr_x(x_b), .o_addr_w(w_b),
        .acc(acc_b), .rst_acc(racc_b), .wr_w(wr_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic handle(input bit which, input int kind, input int a, input int b, input int c);
        ev_t e;
        string tag;
        bit empty;
        tag = which ? "dut0" : "dut";
        empty = which ? (qb.size() == 0) : (qa.size() == 0);
        checks++;
        if (empty) begin
            errors++;
            $display("FAIL %s unexpected event: got kind=%0d a=%0d b=%0d c=%0d at cycle %0d, expected none",
                     tag, kind, a, b, c, cyc);
        end else begin
            if (which) e = qb.pop_front();
            else       e = qa.pop_front();
            if (e.kind != kind || e.a != a || e.b != b || e.c != c || e.cyc != cyc) begin
                errors++;
                $display("FAIL %s event: got kind=%0d a=%0d b=%0d c=%0d cyc=%0d expected kind=%0d a=%0d b=%0d c=%0d cyc=%0d",
                         tag, kind, a, b, c, cyc, e.kind, e.a, e.b, e.c, e.cyc);
            end
        end
    endtask

    // Expected events of one pass started by a start pulse driven in cycle
    // `base`. Events at relative cycle >= stop_rel are not expected.
    task automatic gen_pass(input bit which, input int base, input int ts, input int nc,
                            input int ni, input int dl, input int done_rel, input int stop_rel);
        int p;
        int e;
        ev_t ev;
        p = ts + dl + 1;
        e = 0;
        for (int j = 0; j < nc; j++) begin
            for (int i = 0; i < ni; i++) begin
                for (int t = 0; t < ts; t++) begin
                    ev = '{0, t * nc + j, t * ni + i, 2, base + e * p + 1 + t};
                    if (e * p + 1 + t < stop_rel) begin
                        if (which) qb.push_back(ev); else qa.push_back(ev);
                    end
                end
                ev = '{1, j * ni + i, 0, 3, base + e * p + p};
                if (e * p + p < stop_rel) begin
                    if (which) qb.push_back(ev); else qa.push_back(ev);
                end
                e++;
            end
        end
        ev = '{2, 0, 0, 1, base + done_rel};
        if (done_rel < stop_rel) begin
            if (which) qb.push_back(ev); else qa.push_back(ev);
        end
    endtask

    task automatic wait_done(input bit which, input int limit, input string name);
        bit found;
        found = 1'b0;
        for (int n = 0; n < limit && !found; n++) begin
            @(negedge clk);
            if (which ? done_b : done_a) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: done not seen within %0d cycles", name, limit);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        if (acc_a)  handle(1'b0, 0, int'(d_a), int'(x_a), int'({busy_a, racc_a}));
        if (wr_a)   handle(1'b0, 1, int'(w_a), 0, int'({busy_a, racc_a}));
        if (done_a) handle(1'b0, 2, 0, 0, int'({busy_a, racc_a}));
    end

    always @(negedge clk) begin
        if (acc_b)  handle(1'b1, 0, int'(d_b), int'(x_b), int'({busy_b, racc_b}));
        if (wr_b)   handle(1'b1, 1, int'(w_b), 0, int'({busy_b, racc_b}));
        if (done_b) handle(1'b1, 2, 0, 0, int'({busy_b, racc_b}));
    end

    initial begin
        int base;

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_addr_d", int'(d_a), 0);
        chk("rst_addr_x", int'(x_a), 0);
        chk("rst_addr_w", int'(w_a), 0);
        chk("rst_acc_out", int'(acc_a), 0);
        chk("rst_wr_w", int'(wr_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_rst_acc", int'(racc_a), 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_busy", int'(busy_a), 0);
        chk("idle_rst_acc", int'(racc_a), 1);

        // Pass 1, with an extra start while busy that must be ignored
        @(negedge clk);
        base = cyc;
        gen_pass(1'b0, base, 3, 2, 3, 1, 31, 1000);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("busy_after_start", int'(busy_a), 1);
        repeat (8) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1'b0, 60, "pass1_done");
        chk("pass1_length", cyc - base, 31);

        // Pass 2 started in the done cycle
        base = cyc;
        gen_pass(1'b0, base, 3, 2, 3, 1, 31, 1000);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1'b0, 60, "pass2_done");
        chk("pass2_length", cyc - base, 31);

        // Pass 3 aborted by reset during the WAIT of element 2 (cycle 9)
        @(negedge clk);
        base = cyc;
        gen_pass(1'b0, base, 3, 2, 3, 1, 31, 10);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_acc", int'(acc_a), 0);
        chk("abort_wr_w", int'(wr_a), 0);
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_rst_acc", int'(racc_a), 1);
        chk("abort_addr_w", int'(w_a), 0);
        repeat (20) @(negedge clk);

        // Pass 4 restarts from element 0
        base = cyc;
        gen_pass(1'b0, base, 3, 2, 3, 1, 31, 1000);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1'b0, 60, "pass4_done");

        // DELAY=0, TIMESTEP=1 instance
        @(negedge clk);
        base = cyc;
        gen_pass(1'b1, base, 1, 2, 3, 0, 13, 1000);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_done(1'b1, 40, "dut0_done");
        chk("dut0_length", cyc - base, 13);

        repeat (3) @(negedge clk);
        chk("dut_events_left", qa.size(), 0);
        chk("dut0_events_left", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addr_gen_upd_w.md
# addr_gen_upd_w

Address generator and sequencer for the LSTM weight-gradient/update pass.
- Starts after back-propagation has filled the delta-gate memories.
- For every weight element W[j][i], it accumulates dgate[t][j]·x[t][i] over all timesteps.
- When the sum is ready, it writes the updated element back.
- Sits between `fsm_bp` and the datapath's weight memories.
- One instance per gate-weight group; W and U memories each get their own instance.

## Interface

Parameters:
- ADDR_WIDTH, 12: width of every address output.
- TIMESTEP, 7: number of timesteps summed per weight element (≥1).
- NUM_CELL, 8: rows j of the weight matrix; also the stride of the delta-gate memory.
- NUM_INPUT, 53: columns i of the weight matrix; also the stride of the x/h memory.
- DELAY, 2: extra cycles from the last `acc` to `wr_w`, covering MAC and update latency (≥0).

Ports:
- clk, in, 1: single clock. All logic updates on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle request to run a full update pass.
- o_addr_d, out, ADDR_WIDTH: delta-gate read address, t·NUM_CELL + j.
- o_addr_x, out, ADDR_WIDTH: input/hidden read address, t·NUM_INPUT + i.
- o_addr_w, out, ADDR_WIDTH: weight address j·NUM_INPUT + i. Used as the read address for the old weight and as the write address.
- acc, out, 1: MAC accumulate enable.
- rst_acc, out, 1: clears the MAC accumulator.
- wr_w, out, 1: weight write strobe.
- busy, out, 1: high from the cycle after `start` is accepted until `done`.
- done, out, 1: one-cycle pulse when the pass completes.

## Operation

State machine states: IDLE, ACC, WAIT, WR.

Counters:
- t runs 0..TIMESTEP-1.
- i runs 0..NUM_INPUT-1 (inner loop).
- j runs 0..NUM_CELL-1 (outer loop).
- d counts WAIT cycles, 0..DELAY-1.

Address arithmetic:
- No multipliers.
- Keep base registers and advance them with adders: +NUM_CELL and +NUM_INPUT per t step, +1 per i step, j base steps by NUM_INPUT.
- All addresses are modulo 2^ADDR_WIDTH. Sizing parameters so nothing wraps is the integrator's responsibility.

State behaviour:
- **IDLE**
  - rst_acc=1; acc=0; wr_w=0; busy=0.
  - start=1 → ACC with t=i=j=0.
- **ACC**
  - acc=1; rst_acc=0.
  - o_addr_d and o_addr_x reflect the current (t,i,j).
  - If t<TIMESTEP-1: t+1.
  - Otherwise: t←0, then go to WAIT, or directly to WR if DELAY=0.
- **WAIT**
  - acc=0 and addresses hold.
  - After DELAY cycles → WR.
- **WR**
  - wr_w=1 and rst_acc=1 for exactly one cycle.
  - o_addr_w = j·NUM_INPUT + i.
  - Then advance i, wrapping into j.
  - If (i,j) was (NUM_INPUT-1, NUM_CELL-1): go to IDLE and pulse done on the next cycle.
  - Otherwise: go to ACC.

Boundary conditions:
- `start` while busy=1 is ignored and not queued.
- `start` in the same cycle as `done` is accepted; the new pass begins immediately.
- `rst` mid-pass aborts at once. Next cycle: IDLE with all counters zeroed. No partial write is issued after the reset edge.
- TIMESTEP=1: exactly one ACC cycle per element.
- NUM_CELL=1 or NUM_INPUT=1: must work with no special casing.

## Timing

- All outputs are registered.
- Reset values: o_addr_d=o_addr_x=o_addr_w=0, acc=0, wr_w=0, busy=0, done=0, rst_acc=1.
- With `start` sampled at edge k:
  - acc is high in cycles k+1 .. k+TIMESTEP.
  - WAIT occupies k+TIMESTEP+1 .. k+TIMESTEP+DELAY.
  - wr_w is high in cycle k+TIMESTEP+DELAY+1.
- Cycles per element: TIMESTEP+DELAY+1.
- Pass length: NUM_CELL·NUM_INPUT·(TIMESTEP+DELAY+1) cycles. Defaults give 4240.
- done pulses one cycle after the final wr_w. busy falls in that same cycle.
- Memory read latency is absorbed by DELAY in the datapath. This block issues no pipeline compensation of its own.

## Structure

- Shared package (`lstm_pkg`):
  - state enum for the four states;
  - default ADDR_WIDTH, TIMESTEP and layer-size constants, shared with `fsm_bp` and the other address generators.
- One sub-module, `cnt_wrap`: a parameterised counter with enable, synchronous clear, max value, and a wrap flag. Instantiate it for t, i, j and d.
- Stride accumulators stay in the top module.

## Test plan

Bench parameters unless noted: TIMESTEP=3, NUM_CELL=2, NUM_INPUT=3, DELAY=1.

1. **Reset values:** assert rst for 2 cycles → all outputs zero except rst_acc=1; no start → state stays IDLE indefinitely.
2. **First element:** pulse start → o_addr_d=0,2,4 and o_addr_x=0,3,6 with acc=1 over 3 cycles; 1 WAIT cycle; then wr_w=1, o_addr_w=0, rst_acc=1.
3. **Traversal:**
   - second element: o_addr_x=1,4,7, o_addr_d=0,2,4, o_addr_w=1;
   - element (j=1,i=0): o_addr_d=1,3,5, o_addr_x=0,3,6, o_addr_w=3;
   - last write: o_addr_w=5;
   - done pulses exactly 30 cycles after the start edge + 1; busy falls in the same cycle.
4. **Handshake:**
   - start re-asserted while busy → ignored, pass length unchanged;
   - start coincident with done → second pass begins with the identical address sequence.
5. **Mid-pass reset:** rst asserted during WAIT of element 2 → no wr_w follows; next start restarts from o_addr_w=0.
6. **DELAY=0, TIMESTEP=1:** wr_w follows each single acc cycle directly; 12 cycles for 6 elements; o_addr_w sequence 0..5.
